branch_target_unit: RTL

BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

---
 rtl/branch_target_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/branch_target_unit.sv
// Branch target/next-PC resolution with a 2-bit saturating-counter branch history table.
// Optional macro BTU_BYPASS_EN forwards a same-cycle table write to the pred_taken lookup.
module branch_target_unit #(
  parameter int WordSize = 32,
  parameter int BhtDepth = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid_in,
  input  logic                addr_mode,
  input  logic                is_cond,
  input  logic                branch_taken,
  input  logic                pred_taken_in,
  input  logic [WordSize-1:0] imm,
  input  logic [WordSize-1:0] rs1d,
  input  logic [WordSize-1:0] pc_in,
  input  logic                stall,
  input  logic                flush,
  input  logic [WordSize-1:0] pred_pc,
  output logic                pred_taken,
  output logic                out_valid,
  output logic                mispredict,
  output logic [WordSize-1:0] branch_addr,
  output logic [WordSize-1:0] npc
);

  localparam int IdxW = $clog2(BhtDepth);

  logic [IdxW-1:0]     upd_idx;
  logic [IdxW-1:0]     look_idx;
  logic                accept;
  logic                train;
  logic [1:0]          upd_cur;
  logic [1:0]          upd_value;
  logic [1:0]          look_value;
  logic [1:0]          ctr_q [BhtDepth];
  logic [WordSize-1:0] reg_sum;
  logic [WordSize-1:0] target;
  logic                unused_pred_bits;

  assign upd_idx  = pc_in[IdxW+1:2];
  assign look_idx = pred_pc[IdxW+1:2];
  assign accept   = valid_in && !stall && !flush;
  assign train    = accept && is_cond;

  // Only the word-index bits of the lookup PC address the table.
  assign unused_pred_bits = ^{pred_pc[WordSize-1:IdxW+2], pred_pc[1:0]};

  always_comb begin
    upd_cur   = ctr_q[upd_idx];
    upd_value = upd_cur;
    if (branch_taken) begin
      if (upd_cur != 2'd3) upd_value = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'd0) upd_value = upd_cur - 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < BhtDepth; gi++) begin : g_bht
      logic [1:0] cnt_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= 2'd1;
        end else if (train && (upd_idx == IdxW'(gi))) begin
          cnt_reg <= upd_value;
        end
      end
      assign ctr_q[gi] = cnt_reg;
    end
  endgenerate

  always_comb begin
    look_value = ctr_q[look_idx];
`ifdef BTU_BYPASS_EN
    if (train && (upd_idx == look_idx)) look_value = upd_value;
`endif
  end

  assign pred_taken = look_value[1];

  // Register-relative targets are halfword aligned: bit 0 is dropped.
  assign reg_sum = imm + rs1d;
  assign target  = addr_mode ? {reg_sum[WordSize-1:1], 1'b0} : (pc_in + imm);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      mispredict  <= 1'b0;
      branch_addr <= '0;
      npc         <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      mispredict <= 1'b0;
    end else if (!stall) begin
      if (valid_in) begin
        out_valid   <= 1'b1;
        mispredict  <= (branch_taken != pred_taken_in);
        branch_addr <= target;
        npc         <= branch_taken ? target : pc_in;
      end else begin
        out_valid  <= 1'b0;
        mispredict <= 1'b0;
      end
    end
  end

endmodule
